// File: rtl/mem_dma.sv
// Word-copy DMA engine: CPU-programmed register window plus a bus initiator port.
// Optional constant-fill mode is compiled in with MEM_DMA_FILL_EN.
module mem_dma #(
  parameter logic [31:0] ADDR     = 32'h4000_7000,
  parameter int unsigned LEN_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        dma_sel,
  output logic        dma_ready,
  output logic [31:0] dma_rdata,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_ready,
  input  logic [31:0] m_rdata
);

  typedef enum logic [2:0] {StIdle, StRd, StGapR, StWr, StGapW} state_e;

  state_e              state_q, state_d;
  logic [31:0]         src_q, src_d, dst_q, dst_d, buf_q, buf_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic                done_q, done_d, aborted_q, aborted_d, pend_q, pend_d;
  logic                fill_q, fill_d;
  logic                ready_q;
  logic [31:0]         rdata_q, rd_mux;
  logic                m_valid_q;
  logic [31:0]         m_addr_q, m_wdata_q;
  logic [3:0]          m_wstrb_q;

  logic       reg_acc, reg_wr, ctrl_wr, start, abort, busy, hs;
  logic [1:0] reg_off;
  logic       unused_addr;

  assign dma_sel     = mem_valid && (mem_addr[31:4] == ADDR[31:4]);
  assign reg_off     = mem_addr[3:2];
  assign unused_addr = ^mem_addr[1:0];
  // One access per request: act only on the edge where dma_ready rises.
  assign reg_acc     = dma_sel && !ready_q;
  assign reg_wr      = reg_acc && (mem_wstrb != 4'h0);
  assign ctrl_wr     = reg_wr && (reg_off == 2'd3);
  assign start       = ctrl_wr && mem_wdata[0];
  assign abort       = ctrl_wr && mem_wdata[1];
  assign busy        = (state_q != StIdle);
  assign hs          = m_valid_q && m_ready;

`ifdef MEM_DMA_FILL_EN
  assign fill_d = (state_q == StIdle && start) ? mem_wdata[2] : fill_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fill_q <= 1'b0;
    else       fill_q <= fill_d;
  end
`else
  assign fill_q = 1'b0;
  assign fill_d = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    buf_d     = buf_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    pend_d    = pend_q;

    if (reg_wr && !busy) begin
      case (reg_off)
        2'd0:    src_d = mem_wdata;
        2'd1:    dst_d = mem_wdata;
        2'd2:    len_d = mem_wdata[LEN_BITS-1:0];
        default: ;
      endcase
    end
    if (abort && busy) pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          done_d    = 1'b0;
          aborted_d = 1'b0;
          if (abort)               aborted_d = 1'b1;
          else if (len_q == '0)    done_d    = 1'b1;
          else                     state_d   = fill_d ? StWr : StRd;
        end
      end
      StRd: begin
        if (hs) begin
          buf_d   = m_rdata;
          state_d = StGapR;
        end
      end
      StGapR: begin
        // A pending abort here drops the word that was just read.
        if (pend_q || abort) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
          pend_d    = 1'b0;
        end else begin
          state_d = StWr;
        end
      end
      StWr: begin
        if (hs) begin
          if (!fill_q) src_d = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          len_d   = len_q - LEN_BITS'(1);
          state_d = StGapW;
        end
      end
      StGapW: begin
        if (pend_q || abort) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
          pend_d    = 1'b0;
        end else if (len_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          state_d = fill_q ? StWr : StRd;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_mux = 32'h0;
    case (reg_off)
      2'd0:    rd_mux = {src_q[31:2], 2'b00};
      2'd1:    rd_mux = {dst_q[31:2], 2'b00};
      2'd2:    rd_mux = 32'(len_q);
      default: rd_mux = {28'h0, fill_q, aborted_q, done_q, busy};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      src_q     <= 32'h0;
      dst_q     <= 32'h0;
      len_q     <= '0;
      buf_q     <= 32'h0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      pend_q    <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= 32'h0;
      m_valid_q <= 1'b0;
      m_addr_q  <= 32'h0;
      m_wdata_q <= 32'h0;
      m_wstrb_q <= 4'h0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      buf_q     <= buf_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      pend_q    <= pend_d;
      ready_q   <= dma_sel;
      if (reg_acc) rdata_q <= rd_mux;
      // Initiator outputs are registered from the next state.
      m_valid_q <= (state_d == StRd) || (state_d == StWr);
      m_wstrb_q <= (state_d == StWr) ? 4'hF : 4'h0;
      if (state_d == StRd) m_addr_q <= {src_d[31:2], 2'b00};
      if (state_d == StWr) begin
        m_addr_q  <= {dst_d[31:2], 2'b00};
        m_wdata_q <= fill_d ? src_d : buf_d;
      end
    end
  end

  assign dma_ready = ready_q;
  assign dma_rdata = rdata_q;
  assign m_valid   = m_valid_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_wstrb   = m_wstrb_q;

endmodule

// File: tb/tb_mem_dma.sv
// Scoreboard bench for mem_dma: stimulus queues expected bus and register traffic,
// monitor processes pop and compare as the DUT presents it.
module tb_mem_dma;
  localparam logic [31:0] BASE = 32'h4000_7000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = 32'h0, mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic        dma_sel, dma_ready;
  logic [31:0] dma_rdata;
  logic        m_valid;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready = 1'b0;
  logic [31:0] m_rdata = 32'h0;

  mem_dma dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .dma_sel(dma_sel),
    .dma_ready(dma_ready), .dma_rdata(dma_rdata), .m_valid(m_valid), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          rel;
  } bus_t;

  bus_t        exp_bus[$];
  bus_t        e;
  logic [31:0] exp_rd[$];
  string       exp_nm[$];
  logic [31:0] mem [logic [31:0]];

  int tests = 0, fails = 0, cyc = 0;
  int hs_cnt = 0, wr_idx = 0, stall_at = -1, stall_left = 0, rd_block_at = -1;
  int xfer_cyc = 0;
  bit stalling = 1'b0, rd_check = 1'b0, prev_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: decides m_ready for the request presented after each edge.
  always @(posedge clk) begin
    #1;
    if (m_valid && m_wstrb == 4'hF && wr_idx == stall_at && stall_left > 0) begin
      m_ready = 1'b0;
      stall_left--;
      stalling = 1'b1;
    end else if (m_valid && m_wstrb == 4'h0 && hs_cnt == rd_block_at) begin
      m_ready = 1'b0;
    end else begin
      m_ready = 1'b1;
      stalling = 1'b0;
    end
    m_rdata = mem_at(m_addr);
  end

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      hs_cnt++;
      if (exp_bus.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL bus_unexpected: got addr %h strb %h, expected no transfer",
                 m_addr, m_wstrb);
      end else begin
        e = exp_bus.pop_front();
        chk("bus_addr", m_addr, e.addr);
        chk("bus_wstrb", {28'h0, m_wstrb}, {28'h0, e.wstrb});
        if (e.wstrb == 4'hF) chk("bus_wdata", m_wdata, e.wdata);
        if (e.rel >= 0) chk("bus_timing", cyc - xfer_cyc, e.rel);
      end
      if (m_wstrb == 4'hF) begin
        mem[m_addr] = m_wdata;
        wr_idx++;
      end
    end
    if (dma_ready && !prev_rdy && rd_check) begin
      if (exp_rd.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL reg_unexpected: got %h, expected no check", dma_rdata);
      end else begin
        chk(exp_nm.pop_front(), dma_rdata, exp_rd.pop_front());
      end
    end
    prev_rdy = dma_ready;
  end

  task automatic bus_acc(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input bit check, output logic [31:0] rdata);
    bit ok = 1'b0;
    @(negedge clk);
    rd_check  = check;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (dma_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok && wstrb != 4'h0 && addr[3:2] == 2'd3 && wdata[0]) xfer_cyc = cyc;
    rdata = dma_rdata;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL reg_port_timeout: got dma_ready 0, expected 1");
    end
    @(negedge clk);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    logic [31:0] x;
    bus_acc(BASE + {28'h0, off}, d, 4'hF, 1'b0, x);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] off, input logic [31:0] expv);
    logic [31:0] x;
    exp_rd.push_back(expv);
    exp_nm.push_back(name);
    bus_acc(BASE + {28'h0, off}, 32'h0, 4'h0, 1'b1, x);
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] x;
    for (int i = 0; i < 100; i++) begin
      bus_acc(BASE + 32'hC, 32'h0, 4'h0, 1'b0, x);
      if (!x[0]) return;
    end
    tests++;
    fails++;
    $display("FAIL %s_idle_timeout: got BUSY 1, expected 0", name);
  endtask

  task automatic push_rd(input logic [31:0] a, input int rel);
    exp_bus.push_back('{addr: a, wstrb: 4'h0, wdata: 32'h0, rel: rel});
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input int rel);
    exp_bus.push_back('{addr: a, wstrb: 4'hF, wdata: d, rel: rel});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] words[4];
    int base;
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
    for (int i = 0; i < 4; i++) mem[32'h10 + 4 * i] = words[i];
    for (int i = 0; i < 8; i++) mem[32'h40 + 4 * i] = 32'h100 + i;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", {31'h0, m_valid}, 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_wdata", m_wdata, 32'h0);
    chk("rst_m_wstrb", {28'h0, m_wstrb}, 32'h0);
    chk("rst_dma_ready", {31'h0, dma_ready}, 32'h0);
    chk("rst_dma_rdata", dma_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Address decode is combinational.
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = BASE + 32'h8;
    #1 chk("sel_hit", {31'h0, dma_sel}, 32'h1);
    mem_addr = 32'h4000_7010;
    #1 chk("sel_miss", {31'h0, dma_sel}, 32'h0);
    mem_valid = 1'b0;

    // Zero-wait copy of four words: RD/WR handshakes every 2 cycles, 4 per word.
    wr(4'h0, 32'h10);
    wr(4'h4, 32'h2000_0100);
    wr(4'h8, 32'd4);
    for (int w = 0; w < 4; w++) begin
      push_rd(32'h10 + 4 * w, 4 * w);
      push_wr(32'h2000_0100 + 4 * w, words[w], 4 * w + 2);
    end
    wr(4'hC, 32'h1);
    wait_idle("copy");
    rd_chk("copy_ctrl", 4'hC, 32'h2);
    rd_chk("copy_len", 4'h8, 32'h0);
    rd_chk("copy_dst", 4'h4, 32'h2000_0110);
    rd_chk("copy_src", 4'h0, 32'h20);
    for (int w = 0; w < 4; w++) chk("copy_ram", mem_at(32'h2000_0100 + 4 * w), words[w]);
    chk("copy_drained", exp_bus.size(), 32'h0);

    // Abort while the third write is stalled: that write still lands.
    wr(4'h0, 32'h40);
    wr(4'h4, 32'h2000_0300);
    wr(4'h8, 32'd8);
    for (int w = 0; w < 3; w++) begin
      push_rd(32'h40 + 4 * w, -1);
      push_wr(32'h2000_0300 + 4 * w, 32'h100 + w, -1);
    end
    stall_at   = wr_idx + 2;
    stall_left = 5;
    wr(4'hC, 32'h1);
    for (int i = 0; i < 100 && !stalling; i++) @(negedge clk);
    chk("abort_stall_seen", {31'h0, stalling}, 32'h1);
    wr(4'hC, 32'h2);
    wait_idle("abort");
    stall_at = -1;
    rd_chk("abort_ctrl", 4'hC, 32'h4);
    rd_chk("abort_len", 4'h8, 32'd5);
    rd_chk("abort_dst", 4'h4, 32'h2000_030C);
    chk("abort_last_wr", mem_at(32'h2000_0308), 32'h102);
    chk("abort_drained", exp_bus.size(), 32'h0);

    // LEN=0: immediate DONE, ABORTED cleared, no bus traffic.
    wr(4'h8, 32'd0);
    wr(4'hC, 32'h1);
    rd_chk("len0_ctrl", 4'hC, 32'h2);

    // START|ABORT together: abort wins.
    wr(4'h8, 32'd5);
    wr(4'hC, 32'h3);
    rd_chk("start_abort_ctrl", 4'hC, 32'h4);
    rd_chk("start_abort_len", 4'h8, 32'd5);

`ifndef MEM_DMA_FILL_EN
    wr(4'h8, 32'd0);
    wr(4'hC, 32'h5);
    rd_chk("fill_ignored_ctrl", 4'hC, 32'h2);
`endif

    // Busy lockout: DST write and a second START mid-transfer are ignored.
    wr(4'h0, 32'h10);
    wr(4'h4, 32'h2000_0200);
    wr(4'h8, 32'd3);
    for (int w = 0; w < 3; w++) begin
      push_rd(32'h10 + 4 * w, -1);
      push_wr(32'h2000_0200 + 4 * w, words[w], -1);
    end
    wr(4'hC, 32'h1);
    wr(4'h4, 32'hDEAD_BEEF);
    wr(4'hC, 32'h1);
    wait_idle("lockout");
    rd_chk("lockout_dst", 4'h4, 32'h2000_020C);
    rd_chk("lockout_ctrl", 4'hC, 32'h2);
    rd_chk("lockout_len", 4'h8, 32'h0);
    chk("lockout_drained", exp_bus.size(), 32'h0);

    // Reset during the read of word 2 (held off by the responder).
    wr(4'h0, 32'h10);
    wr(4'h4, 32'h2000_0400);
    wr(4'h8, 32'd4);
    push_rd(32'h10, 0);
    push_wr(32'h2000_0400, 32'h11, 2);
    base        = hs_cnt;
    rd_block_at = base + 2;
    wr(4'hC, 32'h1);
    for (int i = 0; i < 50 && !(hs_cnt == base + 2 && m_valid && m_wstrb == 4'h0); i++)
      @(negedge clk);
    chk("reset_in_rd2", {31'h0, m_valid}, 32'h1);
    reset = 1'b1;
    #1 chk("reset_m_valid", {31'h0, m_valid}, 32'h0);
    repeat (2) @(negedge clk);
    reset       = 1'b0;
    rd_block_at = -1;
    rd_chk("reset_src", 4'h0, 32'h0);
    rd_chk("reset_dst", 4'h4, 32'h0);
    rd_chk("reset_len", 4'h8, 32'h0);
    rd_chk("reset_ctrl", 4'hC, 32'h0);
    chk("reset_drained", exp_bus.size(), 32'h0);

`ifdef MEM_DMA_FILL_EN
    // Fill: three writes of the SRC word, 2 cycles each, no reads.
    wr(4'h0, 32'hA5A5_A5A5);
    wr(4'h4, 32'h1000_0000);
    wr(4'h8, 32'd3);
    for (int w = 0; w < 3; w++) push_wr(32'h1000_0000 + 4 * w, 32'hA5A5_A5A5, 2 * w);
    wr(4'hC, 32'h5);
    wait_idle("fill");
    rd_chk("fill_ctrl", 4'hC, 32'hA);
    rd_chk("fill_src", 4'h0, 32'hA5A5_A5A4);
    rd_chk("fill_dst", 4'h4, 32'h1000_000C);
    rd_chk("fill_len", 4'h8, 32'h0);
    chk("fill_drained", exp_bus.size(), 32'h0);
`endif

    chk("reg_drained", exp_rd.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_dma.md
# mem_dma

Word-copy DMA engine for the SoC's native memory bus. A peripheral register port, decoded like the other 0x4000_xxxx devices, lets the CPU program source, destination and length. A second port acts as a bus initiator, reading and writing ROM, FRAM and RAM word by word. The initiator port reaches the memory decoder through the SoC bus arbiter, which lives outside this block.

## Interface
- `ADDR`, 32'h4000_7000: register window base; 16-byte window.
- `LEN_BITS`, 16: width of the word-count register.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_valid`  in  1  CPU bus request.
- `mem_addr`  in  32  CPU bus address.
- `mem_wdata`  in  32  CPU write data.
- `mem_wstrb`  in  4  CPU byte strobes; 0 means read.
- `dma_sel`  out  1  combinational: `mem_valid && mem_addr[31:4] == ADDR[31:4]`.
- `dma_ready`  out  1  register-port ready.
- `dma_rdata`  out  32  register read data, valid while `dma_ready` is high.
- `m_valid`  out  1  initiator request.
- `m_addr`  out  32  initiator address; always word aligned.
- `m_wdata`  out  32  initiator write data.
- `m_wstrb`  out  4  4'h0 on reads, 4'hF on writes.
- `m_ready`  in  1  initiator ready from the arbiter.
- `m_rdata`  in  32  initiator read data, sampled on `m_valid && m_ready`.

## Operation
- Register map (offset from `ADDR`):
  - 0x0 SRC: bits [1:0] always read 0.
  - 0x4 DST: bits [1:0] always read 0.
  - 0x8 LEN: word count, `LEN_BITS` wide, zero-extended on read.
  - 0xC CTRL/STATUS:
    - Write: bit0 START, bit1 ABORT, bit2 FILL.
    - Read: bit0 BUSY, bit1 DONE, bit2 ABORTED, bit3 FILL.
- Register writes honour only `mem_wstrb != 0`; the whole word is written with no byte granularity.
- While BUSY, writes to SRC, DST and LEN are ignored, and START is ignored.
- FSM states:
  - IDLE → RD on START with LEN≠0.
  - RD: `m_valid` high, `m_addr`=SRC. On handshake, latch `m_rdata` into a buffer and go to GAP_R.
  - GAP_R → WR.
  - WR: `m_valid` high, `m_addr`=DST, `m_wdata`=buffer. On handshake: SRC+=4, DST+=4, LEN-=1, go to GAP_W.
  - GAP_W:
    - If ABORT is pending → IDLE, set ABORTED.
    - Else if LEN==0 → IDLE, set DONE.
    - Else → RD.
- START with LEN==0: DONE sets on the next cycle and no bus traffic occurs.
- START clears DONE and ABORTED. START and ABORT written in the same word: abort wins, no transfer, ABORTED=1.
- ABORT is latched as pending. `m_valid` is never withdrawn before `m_ready`, so abort takes effect at the next GAP state. A pending abort in RD skips the write.
- SRC, DST and LEN hold their final values after completion, so they are live progress counters. Addresses wrap modulo 2^32. LEN decrements without underflow, since the FSM exits at 0.

## Timing
- Reset values:
  - All registers, buffer and flags are 0.
  - FSM is in IDLE.
  - `m_valid`=0, `m_addr`=0, `m_wdata`=0, `m_wstrb`=0.
  - `dma_ready`=0, `dma_rdata`=0.
- Reset asserted mid-transfer drops `m_valid` immediately; the transfer is lost.
- `dma_ready` is registered: it is high the cycle after `dma_sel` is first seen high and low the cycle after `dma_sel` falls.
  - A register write takes effect at the edge where `dma_ready` rises.
  - `dma_rdata` is registered on that same edge.
- Initiator outputs are all registered. `m_valid` is low for exactly one cycle (GAP) after every handshake.
- Minimum cost is 4 cycles per word with zero-wait responders: RD, GAP_R, WR, GAP_W. Each `m_ready` wait cycle adds one cycle.
- BUSY rises the cycle after the START write. BUSY falls, and DONE or ABORTED rises, in the same cycle the FSM returns to IDLE.

## Configuration
- `MEM_DMA_FILL_EN`:
  - Defined: CTRL.FILL is a writable flag latched on START. In fill mode the FSM skips RD and GAP_R, goes straight to WR, and writes SRC as constant data. DST increments and SRC is unchanged; cost is 2 cycles per word.
  - Undefined: the FILL bit is ignored on write, reads 0, and no fill logic is synthesised.

## Test plan
- Copy: SRC=0x0000_0010, DST=0x2000_0100, LEN=4, START, with ROM words 0x11,0x22,0x33,0x44 → four RD/WR pairs, RAM 0x2000_0100..0x10C holds the same words. After 16 zero-wait cycles: DONE=1, BUSY=0, LEN=0, DST=0x2000_0110.
- LEN=0, START → DONE=1 one cycle later, `m_valid` never asserted.
- Abort: LEN=8, ABORT written while the 3rd WR is stalled (`m_ready` held low 5 cycles) → that write completes, FSM goes to IDLE, ABORTED=1, DONE=0, LEN=5.
- Busy lockout: during a transfer, write DST=0xDEAD_BEEF and START → DST is unchanged and the transfer is unaffected.
- Reset: assert `reset` during the RD of word 2 → same cycle, `m_valid`=0 and all registers read 0 afterwards.
- Fill (macro defined): SRC=0xA5A5_A5A5, DST=0x1000_0000, LEN=3, FILL|START → three writes of 0xA5A5_A5A5 with no reads, completing in 6 cycles.
